// File: rtl/div_control.sv
// Sequential signed divider: radix-2 restoring division over WIDTH iterations,
// with sign fix-up, divide-by-zero and overflow flagging through data_exception.
module div_control #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH:0]   dv;
  logic [CW-1:0]    cnt;
  logic             sq, sr, ovf, dz;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic             b_zero;
  logic [WIDTH:0]   r_shift, r_trial;
  logic             take;

  assign abs_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign b_zero = (data_operandB == '0);

  // Partial remainder always stays below |B| <= 2^(WIDTH-1), so WIDTH bits hold it
  // between iterations; only the shifted trial value needs the extra bit.
  assign r_shift = {r, q[WIDTH-1]};
  assign r_trial = r_shift - dv;
  assign take    = (r_shift >= dv);

  always_comb begin
    state_n = state;
    case (state)
      ITER:    if (cnt == LAST) state_n = FIX;
      FIX:     state_n = DONE;
      default: state_n = state;
    endcase
    if (ctrl_div) state_n = b_zero ? DONE : ITER;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q              <= '0;
      r              <= '0;
      dv             <= '0;
      cnt            <= '0;
      sq             <= 1'b0;
      sr             <= 1'b0;
      ovf            <= 1'b0;
      dz             <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      busy <= (state_n == ITER) || (state_n == FIX);
      if (ctrl_div) begin
        data_resultRDY <= 1'b0;
        if (state == IDLE || state == DONE) data_exception <= 1'b0;
        sq  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        sr  <= data_operandA[WIDTH-1];
        ovf <= (data_operandA == MIN_NEG) && (data_operandB == ALL_ONES);
        dz  <= b_zero;
        // A zero divisor keeps the raw dividend in q so it can be returned as remainder.
        q   <= b_zero ? data_operandA : abs_a;
        r   <= '0;
        dv  <= {1'b0, abs_b};
        cnt <= '0;
      end else begin
        case (state)
          ITER: begin
            r   <= take ? r_trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], take};
            cnt <= cnt + 1'b1;
          end
          FIX: begin
            data_result    <= ovf ? MIN_NEG : (sq ? -q : q);
            data_remainder <= ovf ? '0 : (sr ? -r : r);
            data_exception <= ovf;
            data_resultRDY <= 1'b1;
          end
          DONE: begin
            if (dz) begin
              data_result    <= '0;
              data_remainder <= q;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
              dz             <= 1'b0;
            end else begin
              data_resultRDY <= 1'b0;
            end
          end
          default: data_resultRDY <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_control.sv
// Self-checking bench for div_control: cycle-level behavioural model plus
// directed literal cases and randomized start/abort/reset traffic.
module tb_div_control;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         ctrl_div = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] data_result, data_remainder;
  logic         data_exception, data_resultRDY, busy;

  always #5 clk = ~clk;

  div_control #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .ctrl_div(ctrl_div),
    .data_operandA(a), .data_operandB(b),
    .data_result(data_result), .data_remainder(data_remainder),
    .data_exception(data_exception), .data_resultRDY(data_resultRDY),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: signed divide truncating toward zero, remainder follows dividend.
  function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] res, output logic [W-1:0] rem,
                                  output logic exc);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (y == '0) begin
      res = '0; rem = x; exc = 1'b1;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000; rem = '0; exc = 1'b1;
    end else begin
      res = W'(sx / sy); rem = W'(sx % sy); exc = 1'b0;
    end
  endfunction

  // Cycle model: edge counter, pending result with its due edge, busy window.
  int           cyc = 0;
  int           due = -1;
  int           busy_end = -1;
  logic [W-1:0] exp_q[$];
  logic         pend_exc = 1'b0;
  logic [W-1:0] exp_res = '0, exp_rem = '0;
  logic         exp_exc = 1'b0, exp_rdy = 1'b0, exp_busy = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] m_res, m_rem;
    logic         m_exc;
    bit           was_busy;
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
      due = -1; busy_end = -1;
      exp_res = '0; exp_rem = '0; exp_exc = 1'b0; exp_rdy = 1'b0;
    end else begin
      was_busy = (cyc - 1 <= busy_end);
      exp_rdy = 1'b0;
      if (ctrl_div) begin
        if (!was_busy) exp_exc = 1'b0;
        ref_div(a, b, m_res, m_rem, m_exc);
        exp_q.delete();
        exp_q.push_back(m_res);
        exp_q.push_back(m_rem);
        pend_exc = m_exc;
        due = cyc + ((b == '0) ? 1 : 33);
        busy_end = (b == '0) ? -1 : cyc + 32;
      end else if (cyc == due && exp_q.size() == 2) begin
        exp_res = exp_q.pop_front();
        exp_rem = exp_q.pop_front();
        exp_exc = pend_exc;
        exp_rdy = 1'b1;
        due = -1;
      end
    end
    exp_busy = (cyc <= busy_end);
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      check("sb_rdy", W'(data_resultRDY), W'(exp_rdy));
      check("sb_busy", W'(busy), W'(exp_busy));
      check("sb_exception", W'(data_exception), W'(exp_exc));
      check("sb_result", data_result, exp_res);
      check("sb_remainder", data_remainder, exp_rem);
    end
  end

  // Caller sits at a negedge; the strobe is sampled on the following rising edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    ctrl_div = 1'b1; a = x; b = y;
    @(negedge clk);
    ctrl_div = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_rdy(input string name, input int lat, input logic [W-1:0] er,
                          input logic [W-1:0] erm, input logic ee);
    int k = 0;
    while (!data_resultRDY && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, W'(k), W'(lat));
    if (data_resultRDY) begin
      check({name, "_result"}, data_result, er);
      check({name, "_remainder"}, data_remainder, erm);
      check({name, "_exception"}, W'(data_exception), W'(ee));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] x, y, er, erm;
    logic ee;
    repeat (3) @(negedge clk);
    check("reset_result", data_result, '0);
    check("reset_rdy", W'(data_resultRDY), '0);
    check("reset_busy", W'(busy), '0);
    reset_n = 1'b1;
    @(negedge clk);

    start_op(32'd100, 32'd7);
    wait_rdy("basic", 33, 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    check("basic_pulse_width", W'(data_resultRDY), '0);
    check("basic_hold", data_result, 32'd14);

    start_op(-32'sd100, 32'd7);
    wait_rdy("neg_dividend", 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    start_op(32'd100, -32'sd7);
    wait_rdy("neg_divisor", 33, 32'hFFFF_FFF2, 32'd2, 1'b0);
    start_op(-32'sd100, -32'sd7);
    wait_rdy("neg_both", 33, 32'd14, 32'hFFFF_FFFE, 1'b0);

    start_op(32'd55, 32'd0);
    wait_rdy("div_zero", 1, 32'd0, 32'd55, 1'b1);

    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_rdy("overflow", 33, 32'h8000_0000, 32'd0, 1'b1);
    start_op(32'h8000_0000, 32'd2);
    wait_rdy("min_by_two", 33, 32'hC000_0000, 32'd0, 1'b0);
    start_op(32'h7FFF_FFFF, 32'h8000_0000);
    wait_rdy("max_by_min", 33, 32'd0, 32'h7FFF_FFFF, 1'b0);

    start_op(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    start_op(32'd9, 32'd3);
    wait_rdy("restart", 33, 32'd3, 32'd0, 1'b0);

    start_op(32'd100, 32'd7);
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midreset_result", data_result, '0);
    check("midreset_remainder", data_remainder, '0);
    check("midreset_busy", W'(busy), '0);
    repeat (40) @(negedge clk);
    check("midreset_no_rdy", W'(data_resultRDY), '0);

    start_op(32'd100, 32'd7);
    wait_rdy("b2b_first", 33, 32'd14, 32'd2, 1'b0);
    start_op(32'd20, 32'd6);
    check("b2b_prev_cleared_rdy", W'(data_resultRDY), '0);
    wait_rdy("b2b_second", 33, 32'd3, 32'd2, 1'b0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: begin x = $urandom; y = '0; end
        1: begin x = 32'h8000_0000; y = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h8000_0000; end
        2: begin x = $urandom; y = W'($urandom_range(1, 20)); if ($urandom_range(0, 1) == 1) y = -y; end
        default: begin x = $urandom; y = $urandom; end
      endcase
      ref_div(x, y, er, erm, ee);
      start_op(x, y);
      case ($urandom_range(0, 9))
        0, 1: repeat ($urandom_range(0, 35)) @(negedge clk);
        2: begin
          repeat ($urandom_range(0, 35)) @(negedge clk);
          reset_n = 1'b0;
          @(negedge clk);
          reset_n = 1'b1;
        end
        default: wait_rdy("rand", (y == '0) ? 1 : 33, er, erm, ee);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_control.md
# div_control

Sequential 32-bit signed integer divider with its own control FSM. It is the counterpart to the multiplier control path and sits beside it in the ALU's multi-cycle unit. It accepts a one-cycle start strobe, runs a radix-2 restoring division for 32 iterations, then presents quotient and remainder with a one-cycle ready pulse. Divide-by-zero and the single overflow case are flagged through `data_exception`.

## Interface
- `WIDTH`, default 32: operand/result width. Iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock, sole clock domain
- `reset_n`  in  1  reset; synchronous, active-low
- `ctrl_div`  in  1  start strobe; sampled each rising edge
- `data_operandA`  in  WIDTH  dividend, two's complement; sampled only on the start edge
- `data_operandB`  in  WIDTH  divisor, two's complement; sampled only on the start edge
- `data_result`  out  WIDTH  quotient, truncated toward zero
- `data_remainder`  out  WIDTH  remainder; sign follows dividend; |rem| < |divisor|
- `data_exception`  out  1  divide-by-zero or overflow; valid with `data_resultRDY`
- `data_resultRDY`  out  1  one-cycle pulse; result fields valid
- `busy`  out  1  high in ITER and FIX

## Operation
- States: IDLE, ITER, FIX, DONE. DONE behaves as IDLE for accepting a start.
- **Start.** `ctrl_div`=1 at any edge in any state latches A and B, aborts any operation in flight, and clears `data_resultRDY`. Starting from IDLE/DONE also clears `data_exception`.
- **Start with B=0.** Go to DONE. On the next edge: `data_result`=0, `data_remainder`=A, `data_exception`=1, `data_resultRDY`=1.
- **Start with B≠0.**
  - Save the signs: `sq` = A[msb]^B[msb], `sr` = A[msb].
  - Load the quotient register with |A| and the WIDTH+1-bit partial remainder with 0.
  - Load the divisor register with |B|, held as WIDTH+1 bits so |−2^31| is representable.
  - Set the counter to 0 and go to ITER.
- **ITER, each edge:**
  - Shift {R,Q} left by one.
  - Compute trial D = R − |B| at WIDTH+1 bits.
  - If D ≥ 0: R=D and Q[0]=1. Otherwise restore R and set Q[0]=0.
  - Increment the counter. After iteration WIDTH (counter = WIDTH−1 on entry), go to FIX.
- **FIX, one edge:**
  - `data_result` = `sq` ? −Q : Q.
  - `data_remainder` = `sr` ? −R : R.
  - `data_exception` = 1 only for A=0x80000000, B=0xFFFFFFFF. In that case `data_result`=0x80000000 and remainder=0.
  - `data_resultRDY`=1. Go to DONE.
- **DONE:** `data_resultRDY` drops on the next edge. Result, remainder and exception hold until the next start.
- **Reset.** `reset_n`=0 at an edge forces IDLE, counter 0, and all outputs 0. This applies mid-operation too; no partial result is ever flagged ready.
- **Simultaneous events.** Reset beats start. Start in the cycle `data_resultRDY` is high is accepted; the pulse still lasts exactly one cycle.

## Timing
- Start edge = E0.
- Nonzero divisor: iterations occur on E1..E32, FIX on E33. `data_resultRDY` is high between E33 and E34. Latency is 33 edges.
- Zero divisor: `data_resultRDY` is high between E1 and E2. Latency is 1 edge.
- `busy` is high from after E0 through E33 for the nonzero case. It never rises for a zero divisor.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Operand inputs may change freely after E0.

## Test plan
- **Basic.** A=100, B=7, pulse `ctrl_div` → after 33 edges: result=14, remainder=2, exception=0, RDY high exactly 1 cycle, `busy` high for 33 cycles.
- **Signs.** A=−100, B=7 → result=−14 (0xFFFFFFF2), rem=−2. A=100, B=−7 → result=−14, rem=2. A=−100, B=−7 → result=14, rem=−2.
- **Divide by zero.** A=55, B=0 → RDY 1 edge later: exception=1, result=0, remainder=55, `busy` never high.
- **Overflow and extremes.**
  - A=0x80000000, B=−1 → exception=1, result=0x80000000.
  - A=0x80000000, B=2 → result=0xC0000000, exception=0.
  - A=0x7FFFFFFF, B=0x80000000 → result=0, rem=0x7FFFFFFF.
- **Restart/reset.**
  - Start A=100, B=7. Re-strobe with A=9, B=3 at E10 → single RDY 33 edges after E10 with result=3, rem=0.
  - Separately, assert `reset_n`=0 at E20 → all outputs 0, IDLE, no RDY.
- **Back-to-back.** Strobe new operands (A=20, B=6) in the RDY cycle → previous result visible that cycle; new RDY 33 edges later with result=3, rem=2.
